// File: rtl/alu_arbiter_ctrl_pkg.sv
// alu_arbiter_ctrl_pkg: shared widths, opcode encoding and FSM states for the ALU arbiter
package alu_arbiter_ctrl_pkg;
  localparam int OP_W   = 4;
  localparam int OPND_W = 8;
  localparam int RES_W  = 16;
  localparam logic [RES_W-1:0] DIV0_RES = 16'hFFFF;
  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_MUL = 4'h2;
  localparam logic [OP_W-1:0] OP_DIV = 4'h3;
  localparam logic [OP_W-1:0] OP_SHL = 4'h4;
  localparam logic [OP_W-1:0] OP_SHR = 4'h5;
  localparam logic [OP_W-1:0] OP_AND = 4'h6;
  localparam logic [OP_W-1:0] OP_OR  = 4'h7;
  localparam logic [OP_W-1:0] OP_XOR = 4'h8;
  localparam logic [OP_W-1:0] OP_NOT = 4'h9;
  localparam logic [OP_W-1:0] OP_NOP = 4'hA;
  localparam logic [OP_W-1:0] OP_CLR = 4'hB;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_arbiter_ctrl_if.sv
// alu_arbiter_ctrl_if: two-port request/response bus between issue logic and the ALU arbiter
interface alu_arbiter_ctrl_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_err;
  modport master (output req_valid, req_a, req_b, req_op, rsp_ready,
                  input req_ready, rsp_valid, rsp_result, rsp_err);
  modport slave  (input req_valid, req_a, req_b, req_op, rsp_ready,
                  output req_ready, rsp_valid, rsp_result, rsp_err);
endinterface

// File: rtl/alu_arbiter_ctrl_alu.sv
// alu_arbiter_ctrl_alu: combinational 8-bit ALU with 16-bit zero-extended results
module alu_arbiter_ctrl_alu
  import alu_arbiter_ctrl_pkg::*;
(
  input  logic [OPND_W-1:0] a_i,
  input  logic [OPND_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [RES_W-1:0]  res_o,
  output logic              err_o
);
  logic [RES_W-1:0] a, b;
  assign a = {8'b0, a_i};
  assign b = {8'b0, b_i};
  always_comb begin
    res_o = '0;
    err_o = 1'b0;
    case (op_i)
      OP_ADD: res_o = a + b;
      OP_SUB: res_o = a - b;
      OP_MUL: res_o = a * b;
      OP_DIV: res_o = (b == '0) ? '0 : a / b;
      OP_SHL: res_o = a << b_i[3:0];
      OP_SHR: res_o = a >> b_i[3:0];
      OP_AND: res_o = a & b;
      OP_OR:  res_o = a | b;
      OP_XOR: res_o = a ^ b;
      OP_NOT: res_o = ~a;
      default: err_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: round-robin sharing of one ALU between two requesters with response handshake
module alu_arbiter_ctrl
  import alu_arbiter_ctrl_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_ctrl_if.slave bus,
  output logic             busy_o,
  output logic [CNT_W-1:0] ops_done_o
);
  state_t state_q, state_d;
  logic ptr_q, gnt_q, gnt, accept, done, alu_err, cap_err, err_q;
  logic [3:0] cnt_q;
  logic [OPND_W-1:0] a_q, b_q;
  logic [OP_W-1:0] op_q;
  logic [RES_W-1:0] alu_res, cap_res, rsp_q, held_q;
  logic [CNT_W-1:0] ops_q;
  alu_arbiter_ctrl_alu u_alu (.a_i(a_q), .b_i(b_q), .op_i(op_q), .res_o(alu_res), .err_o(alu_err));
  assign gnt    = bus.req_valid[ptr_q] ? ptr_q : ~ptr_q;
  assign accept = (state_q == IDLE) && |bus.req_valid;
  assign done   = (state_q == RESP) && bus.rsp_ready[gnt_q];
  assign busy_o = state_q != IDLE;
  assign ops_done_o = ops_q;
  assign bus.rsp_result = rsp_q;
  assign bus.rsp_err = err_q;
  // NOP/CLR/DIV-by-zero override whatever the ALU produces
  always_comb begin
    cap_res = (op_q == OP_NOP) ? held_q : (op_q == OP_CLR) ? '0 :
              (op_q == OP_DIV && b_q == '0) ? DIV0_RES : alu_res;
    cap_err = (op_q == OP_NOP) ? 1'b0 : (op_q == OP_CLR) ? 1'b1 :
              (op_q == OP_DIV && b_q == '0) ? 1'b1 : alu_err;
  end
  always_comb begin
    state_d = state_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = EXEC;
        bus.req_ready = gnt ? 2'b10 : 2'b01;
      end
      EXEC: if (cnt_q == '0) state_d = RESP;
      RESP: begin
        bus.rsp_valid = gnt_q ? 2'b10 : 2'b01;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
      held_q  <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= gnt ? bus.req_a[15:8] : bus.req_a[7:0];
        b_q   <= gnt ? bus.req_b[15:8] : bus.req_b[7:0];
        op_q  <= gnt ? bus.req_op[7:4] : bus.req_op[3:0];
        gnt_q <= gnt;
        ptr_q <= ~gnt;
        cnt_q <= 4'(EXEC_CYCLES - 1);
      end
      if (state_q == EXEC) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == '0) begin
          rsp_q <= cap_res;
          err_q <= cap_err;
          if (op_q != OP_NOP) held_q <= cap_res;
        end
      end
      if (done && !(&ops_q)) ops_q <= ops_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// tb_alu_arbiter_ctrl: directed vector table plus hand sequences for arbitration, backpressure and reset
module tb_alu_arbiter_ctrl;
  import alu_arbiter_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst1_n = 1'b0, rst4_n = 1'b0;
  logic busy1, busy4;
  logic [15:0] ops1, ops4;
  int n_cmp = 0, n_bad = 0;
  alu_arbiter_ctrl_if m1 ();
  alu_arbiter_ctrl_if m4 ();
  alu_arbiter_ctrl #(.EXEC_CYCLES(1), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst1_n), .bus(m1), .busy_o(busy1), .ops_done_o(ops1));
  alu_arbiter_ctrl #(.EXEC_CYCLES(4), .CNT_W(16)) u4 (.clk(clk), .rst_n(rst4_n), .bus(m4), .busy_o(busy4), .ops_done_o(ops4));
  always #5 clk = ~clk;
  typedef struct {
    int p;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [15:0] res;
    logic err;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic txn(input vec_t v, input logic [15:0] eops);
    int w;
    m1.req_valid = v.p ? 2'b10 : 2'b01;
    if (v.p) begin
      m1.req_a[15:8] = v.a; m1.req_b[15:8] = v.b; m1.req_op[7:4] = v.op;
    end else begin
      m1.req_a[7:0] = v.a; m1.req_b[7:0] = v.b; m1.req_op[3:0] = v.op;
    end
    #1;
    w = 0;
    while (m1.req_ready[v.p] !== 1'b1 && w < 20) begin step(); w++; end
    chk("req_ready", 32'(m1.req_ready), v.p ? 32'd2 : 32'd1);
    step();
    m1.req_valid = 2'b00;
    w = 1;
    while (m1.rsp_valid[v.p] !== 1'b1 && w < 20) begin step(); w++; end
    chk("latency", w, 2);
    chk("rsp_valid", 32'(m1.rsp_valid), v.p ? 32'd2 : 32'd1);
    chk("result", 32'(m1.rsp_result), 32'(v.res));
    chk("err", 32'(m1.rsp_err), 32'(v.err));
    step();
    chk("ops_done", 32'(ops1), 32'(eops));
    chk("busy_after", 32'(busy1), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int w;
    m1.req_valid = 0; m1.req_a = 0; m1.req_b = 0; m1.req_op = 0; m1.rsp_ready = 2'b11;
    m4.req_valid = 0; m4.req_a = 0; m4.req_b = 0; m4.req_op = 0; m4.rsp_ready = 2'b11;
    tv.push_back('{0, 8'd200, 8'd100, OP_ADD, 16'h012C, 1'b0});
    tv.push_back('{1, 8'd9,   8'd0,   OP_DIV, 16'hFFFF, 1'b1});
    tv.push_back('{1, 8'd0,   8'd0,   OP_NOP, 16'hFFFF, 1'b0});
    tv.push_back('{0, 8'd3,   8'd5,   OP_SUB, 16'hFFFE, 1'b0});
    tv.push_back('{0, 8'hF0,  8'h3C,  OP_AND, 16'h0030, 1'b0});
    tv.push_back('{1, 8'hF0,  8'h0F,  OP_OR,  16'h00FF, 1'b0});
    tv.push_back('{0, 8'hFF,  8'h0F,  OP_XOR, 16'h00F0, 1'b0});
    tv.push_back('{1, 8'h0F,  8'h00,  OP_NOT, 16'hFFF0, 1'b0});
    tv.push_back('{0, 8'h81,  8'd4,   OP_SHL, 16'h0810, 1'b0});
    tv.push_back('{1, 8'h80,  8'd3,   OP_SHR, 16'h0010, 1'b0});
    tv.push_back('{0, 8'hFF,  8'hFF,  OP_MUL, 16'hFE01, 1'b0});
    tv.push_back('{1, 8'd200, 8'd7,   OP_DIV, 16'h001C, 1'b0});
    tv.push_back('{0, 8'd7,   8'd7,   OP_CLR, 16'h0000, 1'b1});
    tv.push_back('{1, 8'd0,   8'd0,   OP_NOP, 16'h0000, 1'b0});
    tv.push_back('{0, 8'd1,   8'd2,   OP_ADD, 16'h0003, 1'b0});
    tv.push_back('{1, 8'd1,   8'd2,   4'hF,   16'h0000, 1'b1});
    tv.push_back('{0, 8'd0,   8'd0,   OP_NOP, 16'h0000, 1'b0});
    step();
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_ops", 32'(ops1), 0);
    chk("rst_result", 32'(m1.rsp_result), 0);
    chk("rst_rsp_valid", 32'(m1.rsp_valid), 0);
    chk("rst_req_ready", 32'(m1.req_ready), 0);
    step();
    rst1_n = 1'b1; rst4_n = 1'b1;
    step();
    for (int i = 0; i < tv.size(); i++) txn(tv[i], 16'(i + 1));
    // contention from a fresh reset: port0 first, port1 waits one op, then port0 again
    rst1_n = 1'b0;
    step();
    rst1_n = 1'b1;
    step();
    m1.req_valid = 2'b11;
    m1.req_a = {8'd3, 8'd15}; m1.req_b = {8'd5, 8'd17}; m1.req_op = {OP_SUB, OP_MUL};
    #1;
    chk("arb_ready0", 32'(m1.req_ready), 1);
    step();
    m1.req_valid = 2'b10;
    chk("arb_exec_ready", 32'(m1.req_ready), 0);
    chk("arb_exec_busy", 32'(busy1), 1);
    step();
    chk("arb_rsp0_valid", 32'(m1.rsp_valid), 1);
    chk("arb_rsp0_result", 32'(m1.rsp_result), 32'h00FF);
    step();
    chk("arb_ready1", 32'(m1.req_ready), 2);
    step();
    m1.req_valid = 2'b11;
    m1.req_a[7:0] = 8'd1; m1.req_b[7:0] = 8'd1; m1.req_op[3:0] = OP_ADD;
    step();
    chk("arb_rsp1_valid", 32'(m1.rsp_valid), 2);
    chk("arb_rsp1_result", 32'(m1.rsp_result), 32'hFFFE);
    step();
    chk("arb_ready0_again", 32'(m1.req_ready), 1);
    step();
    m1.req_valid = 2'b00;
    step();
    chk("arb_rsp0b_result", 32'(m1.rsp_result), 32'h0002);
    step();
    chk("arb_ops", 32'(ops1), 3);
    // backpressure: response held for 5 cycles, port1 kept waiting
    m1.rsp_ready = 2'b00;
    m1.req_valid = 2'b01;
    m1.req_a[7:0] = 8'd1; m1.req_b[7:0] = 8'd2; m1.req_op[3:0] = OP_ADD;
    step();
    m1.req_valid = 2'b10;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(m1.rsp_valid), 1);
      chk("bp_result", 32'(m1.rsp_result), 32'h0003);
      chk("bp_req_ready", 32'(m1.req_ready), 0);
      chk("bp_busy", 32'(busy1), 1);
      chk("bp_ops", 32'(ops1), 3);
      step();
    end
    m1.rsp_ready = 2'b01;
    step();
    chk("bp_ops_after", 32'(ops1), 4);
    chk("bp_ready1", 32'(m1.req_ready), 2);
    m1.req_valid = 2'b00;
    m1.rsp_ready = 2'b11;
    step();
    chk("drop_busy", 32'(busy1), 0);
    chk("drop_ops", 32'(ops1), 4);
    // EXEC_CYCLES=4: normal latency, then reset in the middle of EXEC
    m4.req_valid = 2'b10;
    m4.req_a[15:8] = 8'd5; m4.req_b[15:8] = 8'd5; m4.req_op[7:4] = OP_ADD;
    #1;
    chk("x4_ready", 32'(m4.req_ready), 2);
    step();
    m4.req_valid = 2'b00;
    w = 1;
    while (m4.rsp_valid[1] !== 1'b1 && w < 20) begin step(); w++; end
    chk("x4_latency", w, 5);
    chk("x4_result", 32'(m4.rsp_result), 32'h000A);
    step();
    m4.req_valid = 2'b01;
    m4.req_a[7:0] = 8'd2; m4.req_b[7:0] = 8'd3; m4.req_op[3:0] = OP_MUL;
    step();
    m4.req_valid = 2'b00;
    step();
    chk("x4_mid_busy", 32'(busy4), 1);
    rst4_n = 1'b0;
    #1;
    chk("rst_async_busy", 32'(busy4), 0);
    chk("rst_async_result", 32'(m4.rsp_result), 0);
    chk("rst_async_ops", 32'(ops4), 0);
    step();
    rst4_n = 1'b1;
    w = 0;
    for (int i = 0; i < 6; i++) begin
      if (m4.rsp_valid !== 2'b00) w++;
      step();
    end
    chk("rst_no_rsp", w, 0);
    m4.req_valid = 2'b11;
    m4.req_a = {8'd3, 8'd1}; m4.req_b = {8'd5, 8'd1}; m4.req_op = {OP_SUB, OP_ADD};
    #1;
    chk("rst_prio0", 32'(m4.req_ready), 1);
    step();
    m4.req_valid = 2'b00;
    w = 1;
    while (m4.rsp_valid[0] !== 1'b1 && w < 20) begin step(); w++; end
    chk("rst_lat", w, 5);
    chk("rst_result", 32'(m4.rsp_result), 32'h0002);
    step();
    chk("rst_ops_after", 32'(ops4), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
